// File: rtl/if_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage and its buffer.
package if_stage_pkg;

  localparam logic [31:0] INST_NOP     = 32'h0000_0013;
  localparam logic [63:0] PC_RESET_VAL = 64'h8000_0000;

  typedef struct packed {
    logic        misalign;
    logic [63:0] addr;
    logic [31:0] inst;
  } if_entry_t;

endpackage

// File: rtl/if_inst_fifo.sv
// Synchronous instruction buffer between the fetch response path and decode.
module if_inst_fifo
  import if_stage_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  if_entry_t     push_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output if_entry_t     head
);

  localparam int AW = $clog2(FIFO_DEPTH);

  if_entry_t         store [FIFO_DEPTH];
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr;
  logic [CW-1:0]     cnt;
  logic              do_push;
  logic              do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(FIFO_DEPTH));
  assign count   = cnt;
  assign head    = store[rd_ptr];
  assign do_pop  = pop & ~empty;
  // A full buffer still accepts a push when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: PC, credit-limited in-order memory requests, redirect handling
// with wrong-path response dropping, and a registered instruction buffer toward decode.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [63:0] PC_RESET   = PC_RESET_VAL,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  input  logic        id_ready,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [63:0] inst_addr,
  output logic        inst_misalign
);

  localparam int            CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0]   DEPTH_EXT = (CW + 1)'(FIFO_DEPTH);

  logic [63:0]   pc;
  logic [63:0]   rsp_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] outstanding_nxt;
  logic [CW-1:0] drop;
  logic          misalign_pending;
  logic          misalign_push_pending;

  logic          credit_ok;
  logic          req_fire;
  logic          rsp_drop;
  logic          rsp_keep;
  logic          mis_push;

  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  if_entry_t     fifo_in;
  if_entry_t     fifo_head;

  // Every in-flight request reserves a buffer slot, so a response can always be pushed.
  assign credit_ok      = ({1'b0, outstanding} + {1'b0, fifo_count}) < DEPTH_EXT;
  assign imem_req_valid = ~rst & ~redirect_valid & ~misalign_pending & credit_ok;
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid & imem_req_ready;

  assign rsp_drop = (drop != '0);
  assign rsp_keep = imem_rsp_valid & ~rsp_drop & ~redirect_valid;
  // The fault marker waits until all wrong-path words have drained; rsp_pc holds the bad target.
  assign mis_push = misalign_push_pending & ~rsp_drop & ~fifo_full & ~redirect_valid
                  & ~imem_rsp_valid;

  assign fifo_push = rsp_keep | mis_push;
  assign fifo_pop  = inst_valid & id_ready;
  assign fifo_in   = mis_push ? '{misalign: 1'b1, addr: rsp_pc, inst: INST_NOP}
                              : '{misalign: 1'b0, addr: rsp_pc, inst: imem_rsp_data};

  assign outstanding_nxt = outstanding + CW'(req_fire) - CW'(imem_rsp_valid);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc                    <= PC_RESET;
      rsp_pc                <= PC_RESET;
      outstanding           <= '0;
      drop                  <= '0;
      misalign_pending      <= 1'b0;
      misalign_push_pending <= 1'b0;
    end else begin
      outstanding <= outstanding_nxt;
      if (redirect_valid) begin
        pc                    <= redirect_pc;
        rsp_pc                <= redirect_pc;
        drop                  <= outstanding_nxt;
        misalign_pending      <= |redirect_pc[1:0];
        misalign_push_pending <= |redirect_pc[1:0];
      end else begin
        if (req_fire)                   pc     <= pc + 64'd4;
        if (rsp_keep)                   rsp_pc <= rsp_pc + 64'd4;
        if (imem_rsp_valid && rsp_drop) drop   <= drop - 1'b1;
        if (mis_push)                   misalign_push_pending <= 1'b0;
      end
    end
  end

  if_inst_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .pop       (fifo_pop),
    .flush     (redirect_valid),
    .push_data (fifo_in),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head      (fifo_head)
  );

  assign inst_valid    = ~fifo_empty;
  assign inst          = inst_valid ? fifo_head.inst : INST_NOP;
  assign inst_addr     = inst_valid ? fifo_head.addr : 64'd0;
  assign inst_misalign = inst_valid & fifo_head.misalign;

  a_no_rsp_underflow: assert property (@(posedge clk) disable iff (rst)
    !(imem_rsp_valid && outstanding == '0));
  a_outstanding_bound: assert property (@(posedge clk) disable iff (rst)
    ({1'b0, outstanding_nxt} <= DEPTH_EXT));
  a_drop_bound: assert property (@(posedge clk) disable iff (rst)
    (drop <= outstanding));
  a_req_aligned: assert property (@(posedge clk) disable iff (rst)
    !(imem_req_valid && imem_req_addr[1:0] != 2'b00));

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: directed fetch/redirect scenarios plus a random stream.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        id_ready;
  logic        inst_valid;
  logic [31:0] inst;
  logic [63:0] inst_addr;
  logic        inst_misalign;

  always #5 clk = ~clk;

  if_stage #(
    .PC_RESET   (64'h8000_0000),
    .FIFO_DEPTH (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_addr      (inst_addr),
    .inst_misalign  (inst_misalign)
  );

  typedef struct packed {
    logic [63:0] addr;
    logic [31:0] inst;
    logic        mis;
  } exp_t;

  typedef struct packed {
    logic [63:0] addr;
    int unsigned rdy;
  } pend_t;

  exp_t        exp_q[$];
  pend_t       pend_q[$];
  int unsigned pop_cyc[$];
  int          errors = 0;
  int          checks = 0;
  int unsigned cyc = 0;
  int unsigned fire_cnt = 0;
  int unsigned mem_lat = 1;
  logic        mem_hold = 1'b0;
  logic        rand_mode = 1'b0;
  logic [63:0] model_pc = '0;
  logic [63:0] last_fire_addr = '0;

  function automatic logic [31:0] memword(input logic [63:0] a);
    return {a[15:0] ^ 16'hC3A5, a[15:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic push_exp(input logic [63:0] a);
    exp_q.push_back('{addr: a, inst: memword(a), mis: 1'b0});
  endtask

  // Memory: samples request handshakes just before the edge, answers in order after lat cycles.
  initial begin : mem_model
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      #1;
      imem_rsp_valid = 1'b0;
      if (!mem_hold && pend_q.size() > 0 && cyc >= pend_q[0].rdy) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = memword(pend_q[0].addr);
        void'(pend_q.pop_front());
      end
      #3;
      if (rst) begin
        pend_q.delete();
      end else if (imem_req_valid && imem_req_ready) begin
        pend_q.push_back('{addr: imem_req_addr, rdy: cyc + mem_lat});
        fire_cnt++;
        last_fire_addr = imem_req_addr;
        if (rand_mode) begin
          check("rand_req_addr", imem_req_addr, model_pc);
          push_exp(model_pc);
          model_pc = model_pc + 64'd4;
        end
      end
      cyc++;
    end
  end

  // Monitor: every instruction decode consumes is popped from the scoreboard.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && inst_valid && id_ready && !redirect_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_inst: got addr %h inst %h, nothing expected", inst_addr, inst);
        end else begin
          e = exp_q.pop_front();
          check("inst_addr", inst_addr, e.addr);
          check("inst_word", {32'd0, inst}, {32'd0, e.inst});
          check("inst_misalign", {63'd0, inst_misalign}, {63'd0, e.mis});
          pop_cyc.push_back(cyc);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic fetch_n(input int unsigned n);
    int unsigned start;
    start = fire_cnt;
    imem_req_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (fire_cnt - start >= n) break;
    end
    imem_req_ready = 1'b0;
    check("fetch_count", 64'(fire_cnt - start), 64'(n));
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && pend_q.size() == 0) break;
    end
    check("drain_pending", 64'(exp_q.size()), 64'd0);
    tick(2);
  endtask

  initial begin : stim
    int unsigned start;
    rst            = 1'b1;
    imem_req_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    id_ready       = 1'b0;

    // Reset held three cycles
    tick(1);
    check("req_valid_in_reset", {63'd0, imem_req_valid}, 64'd0);
    tick(2);
    rst = 1'b0;
    tick(1);
    check("rst_inst_valid", {63'd0, inst_valid}, 64'd0);
    check("rst_inst_nop", {32'd0, inst}, 64'h13);
    check("rst_inst_addr", inst_addr, 64'd0);
    check("rst_inst_misalign", {63'd0, inst_misalign}, 64'd0);

    // First fetch, response withheld: decode still sees NOP
    id_ready = 1'b1;
    mem_hold = 1'b1;
    push_exp(64'h8000_0000);
    fetch_n(1);
    check("first_fire_addr", last_fire_addr, 64'h8000_0000);
    tick(3);
    check("no_inst_before_rsp", {63'd0, inst_valid}, 64'd0);
    check("nop_before_rsp", {32'd0, inst}, 64'h13);
    mem_hold = 1'b0;
    wait_idle();

    // Streaming with 1-cycle memory
    pop_cyc.delete();
    push_exp(64'h8000_0004);
    push_exp(64'h8000_0008);
    push_exp(64'h8000_000C);
    push_exp(64'h8000_0010);
    fetch_n(4);
    wait_idle();
    check("stream_pops", 64'(pop_cyc.size()), 64'd4);
    if (pop_cyc.size() == 4)
      check("stream_back_to_back", 64'(pop_cyc[3] - pop_cyc[0]), 64'd3);

    // Decode backpressure: credits cap requests at buffer depth
    id_ready = 1'b0;
    start = fire_cnt;
    imem_req_ready = 1'b1;
    tick(10);
    check("bp_req_valid_low", {63'd0, imem_req_valid}, 64'd0);
    imem_req_ready = 1'b0;
    check("bp_fire_count", 64'(fire_cnt - start), 64'd4);
    check("bp_head_valid", {63'd0, inst_valid}, 64'd1);
    check("bp_head_addr", inst_addr, 64'h8000_0014);
    push_exp(64'h8000_0014);
    push_exp(64'h8000_0018);
    push_exp(64'h8000_001C);
    push_exp(64'h8000_0020);
    id_ready = 1'b1;
    wait_idle();

    // Redirect with two responses still in flight
    mem_hold = 1'b1;
    fetch_n(2);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0100;
    #1;
    check("redirect_no_req", {63'd0, imem_req_valid}, 64'd0);
    tick(1);
    redirect_valid = 1'b0;
    mem_hold = 1'b0;
    push_exp(64'h8000_0100);
    push_exp(64'h8000_0104);
    push_exp(64'h8000_0108);
    fetch_n(3);
    wait_idle();

    // Redirect in the same cycle as a response
    mem_hold = 1'b1;
    fetch_n(1);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0300;
    mem_hold = 1'b0;
    tick(1);
    redirect_valid = 1'b0;
    #3;
    check("coincident_fifo_empty", {63'd0, inst_valid}, 64'd0);
    tick(2);
    check("coincident_word_gone", {63'd0, inst_valid}, 64'd0);
    push_exp(64'h8000_0300);
    push_exp(64'h8000_0304);
    fetch_n(2);
    wait_idle();

    // Misaligned target: single fault marker, fetch stalls until the trap redirect
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0102;
    tick(1);
    redirect_valid = 1'b0;
    exp_q.push_back('{addr: 64'h8000_0102, inst: 32'h0000_0013, mis: 1'b1});
    start = fire_cnt;
    imem_req_ready = 1'b1;
    tick(6);
    imem_req_ready = 1'b0;
    check("misalign_no_fetch", 64'(fire_cnt - start), 64'd0);
    wait_idle();
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0200;
    tick(1);
    redirect_valid = 1'b0;
    push_exp(64'h8000_0200);
    push_exp(64'h8000_0204);
    push_exp(64'h8000_0208);
    fetch_n(3);
    check("resume_fire_addr", last_fire_addr, 64'h8000_0208);
    wait_idle();

    // Random ready/latency stream against a reference PC
    model_pc  = 64'h8000_020C;
    rand_mode = 1'b1;
    for (int i = 0; i < 300; i++) begin
      imem_req_ready = 1'($urandom_range(0, 1));
      id_ready       = ($urandom_range(0, 3) != 0);
      mem_lat        = $urandom_range(1, 3);
      tick(1);
    end
    imem_req_ready = 1'b0;
    id_ready       = 1'b1;
    wait_idle();
    rand_mode = 1'b0;
    check("rand_leftover", {63'd0, inst_valid}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
